popcount24_tneuron_acc: RTL

POPCOUNT24_TNEURON_ACC -- requirements
Module: popcount24_tneuron_acc

---
 rtl/popcount24_tneuron_acc.sv | 128 ++++++++++++
 1 files changed

// File: rtl/popcount24_tneuron_acc.sv
// Ternary neuron accumulator: sums (pc_pos - pc_neg) over NCHUNK popcount chunks
// with per-step saturation, then holds a thresholded +1/0/-1 activation until taken.
module popcount24_tneuron_acc #(
    parameter int NCHUNK  = 4,
    parameter int ACC_W   = 8,
    parameter int THR_POS = 10,
    parameter int THR_NEG = -10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              pc_pos,
    input  logic [4:0]              pc_neg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_act,
    output logic signed [ACC_W-1:0] out_sum
);

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    // Saturation bounds expressed at the widened (ACC_W+2) working width.
    localparam logic signed [ACC_W+1:0] WIDE_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W+1:0] WIDE_MIN = {3'b111, {(ACC_W-1){1'b0}}};

    localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THR_POS);
    localparam logic signed [ACC_W-1:0] THR_N = ACC_W'(THR_NEG);

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;
    localparam logic [1:0] ACT_ZERO = 2'b00;

    state_t                  state;
    state_t                  state_next;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sat;
    logic signed [ACC_W+1:0] wide;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              act_next;
    logic                    take;
    logic                    last;

    // Handshake flags are pure state decodes, so no input reaches them combinationally.
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign take      = in_valid & in_ready;
    assign last      = (cnt == CNT_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        acc_sat  = acc;
        act_next = ACT_ZERO;
        wide = {{2{acc[ACC_W-1]}}, acc}
             + {{(ACC_W-3){1'b0}}, pc_pos}
             - {{(ACC_W-3){1'b0}}, pc_neg};
        if (wide > WIDE_MAX) begin
            acc_sat = WIDE_MAX[ACC_W-1:0];
        end else if (wide < WIDE_MIN) begin
            acc_sat = WIDE_MIN[ACC_W-1:0];
        end else begin
            acc_sat = wide[ACC_W-1:0];
        end
        if (acc_sat >= THR_P) begin
            act_next = ACT_POS;
        end else if (acc_sat <= THR_N) begin
            act_next = ACT_NEG;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ACC:  if (take && last) state_next = ST_HOLD;
            ST_HOLD: if (out_ready)    state_next = ST_ACC;
            default:                   state_next = ST_ACC;
        endcase
        if (clr) begin
            state_next = ST_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // clr outranks a same-cycle chunk, and the held result is zeroed on leaving HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_act <= ACT_ZERO;
        end else if (clr) begin
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_act <= ACT_ZERO;
        end else if (take) begin
            if (last) begin
                acc     <= '0;
                cnt     <= '0;
                out_sum <= acc_sat;
                out_act <= act_next;
            end else begin
                acc <= acc_sat;
                cnt <= cnt + 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_sum <= '0;
            out_act <= ACT_ZERO;
        end
    end

endmodule
